args_arb_mux: RTL and testbench

- Registered N-to-1 argument multiplexer with per-channel valid/ready handshake and packet locking.
- Selects the source channel either from an external select (MODE=0) or by round-robin arbitration (MODE=1).
- Once a channel starts a packet, the grant is held until that channel's last beat is accepted.
- Sits between multiple argument producers (e.g. per-object parameter generators) and a single downstream consumer; latency 1 cycle.

---
 rtl/args_arb_mux.sv | 150 +++++++++++++++
 tb/tb_args_arb_mux.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/args_arb_mux.sv
// Registered N-to-1 argument multiplexer with valid/ready handshake, packet locking,
// and either select-driven (MODE=0) or round-robin (MODE=1) channel grant.
module args_arb_mux #(
  parameter int W    = 10,
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [$clog2(N)-1:0] sel,
  input  logic [W*N-1:0]       in_data,
  input  logic [N-1:0]         in_valid,
  input  logic [N-1:0]         in_last,
  output logic [N-1:0]         in_ready,
  output logic [W-1:0]         out_data,
  output logic                 out_valid,
  output logic                 out_last,
  output logic [$clog2(N)-1:0] out_ch,
  input  logic                 out_ready
);

  localparam int SW = $clog2(N);

  logic [W-1:0]  out_data_q,  out_data_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q,  out_last_d;
  logic [SW-1:0] out_ch_q,    out_ch_d;
  logic          lock_q,      lock_d;
  logic [SW-1:0] lock_ch_q,   lock_ch_d;
  logic [SW-1:0] ptr_q,       ptr_d;

  logic [SW-1:0] grant_s;
  logic          grant_valid_s;
  logic          load_s;
  logic          accept_s;
  logic [W-1:0]  grant_data_s;
  logic          grant_last_s;
  logic [N-1:0]  in_ready_s;
  logic          found_s;
  int            idx_s;

  // Grant selection: a held lock overrides both sel and arbitration.
  always_comb begin
    grant_s       = '0;
    grant_valid_s = 1'b0;
    found_s       = 1'b0;
    idx_s         = 0;
    if (lock_q) begin
      grant_s       = lock_ch_q;
      grant_valid_s = 1'b1;
    end else if (MODE == 0) begin
      if (32'(sel) < N) begin
        grant_s       = sel;
        grant_valid_s = 1'b1;
      end else begin
        grant_valid_s = 1'b0;
      end
    end else begin
      // Search starts just past the last channel that finished a packet.
      for (int k = 1; k <= N; k++) begin
        idx_s = (int'(ptr_q) + k) % N;
        if (!found_s && in_valid[idx_s]) begin
          grant_s = idx_s[SW-1:0];
          found_s = 1'b1;
        end else begin
          found_s = found_s;
        end
      end
      grant_valid_s = found_s;
    end
  end

  // Handshake and datapath mux of the granted channel.
  always_comb begin
    load_s       = ~out_valid_q | out_ready;
    in_ready_s   = '0;
    grant_data_s = '0;
    grant_last_s = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_s == SW'(i)) begin
        in_ready_s[i] = load_s & grant_valid_s & ~rst;
        grant_data_s  = in_data[i*W +: W];
        grant_last_s  = in_last[i];
      end else begin
        in_ready_s[i] = 1'b0;
      end
    end
    accept_s = |(in_valid & in_ready_s);
  end

  // Next-state for output register, lock and round-robin pointer.
  always_comb begin
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_ch_d    = out_ch_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;
    ptr_d       = ptr_q;
    if (accept_s) begin
      out_data_d  = grant_data_s;
      out_last_d  = grant_last_s;
      out_ch_d    = grant_s;
      out_valid_d = 1'b1;
      if (grant_last_s) begin
        lock_d = 1'b0;
        if (MODE == 1) begin
          ptr_d = grant_s;
        end else begin
          ptr_d = ptr_q;
        end
      end else begin
        lock_d    = 1'b1;
        lock_ch_d = grant_s;
      end
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_ch_q    <= '0;
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
      ptr_q       <= SW'(N - 1);
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_ch_q    <= out_ch_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
      ptr_q       <= ptr_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_ch    = out_ch_q;

endmodule

// File: tb/tb_args_arb_mux.sv
// Directed bench for args_arb_mux: select mode (N=4), round-robin mode (N=4)
// and select mode with an out-of-range select (N=3).
module tb_args_arb_mux;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // a: MODE=0 N=4
  logic [1:0]  a_sel = '0;
  logic [39:0] a_data = '0;
  logic [3:0]  a_valid = '0, a_last = '0, a_ready;
  logic [9:0]  a_od;
  logic        a_ov, a_ol, a_ordy = 1'b1;
  logic [1:0]  a_och;
  // b: MODE=1 N=4
  logic [1:0]  b_sel = '0;
  logic [39:0] b_data = '0;
  logic [3:0]  b_valid = '0, b_last = '0, b_ready;
  logic [9:0]  b_od;
  logic        b_ov, b_ol, b_ordy = 1'b1;
  logic [1:0]  b_och;
  // c: MODE=0 N=3
  logic [1:0]  c_sel = '0;
  logic [29:0] c_data = '0;
  logic [2:0]  c_valid = '0, c_last = '0, c_ready;
  logic [9:0]  c_od;
  logic        c_ov, c_ol, c_ordy = 1'b1;
  logic [1:0]  c_och;

  args_arb_mux #(.W(10), .N(4), .MODE(0)) dut_a (
    .clk(clk), .rst(rst), .sel(a_sel), .in_data(a_data), .in_valid(a_valid),
    .in_last(a_last), .in_ready(a_ready), .out_data(a_od), .out_valid(a_ov),
    .out_last(a_ol), .out_ch(a_och), .out_ready(a_ordy));
  args_arb_mux #(.W(10), .N(4), .MODE(1)) dut_b (
    .clk(clk), .rst(rst), .sel(b_sel), .in_data(b_data), .in_valid(b_valid),
    .in_last(b_last), .in_ready(b_ready), .out_data(b_od), .out_valid(b_ov),
    .out_last(b_ol), .out_ch(b_och), .out_ready(b_ordy));
  args_arb_mux #(.W(10), .N(3), .MODE(0)) dut_c (
    .clk(clk), .rst(rst), .sel(c_sel), .in_data(c_data), .in_valid(c_valid),
    .in_last(c_last), .in_ready(c_ready), .out_data(c_od), .out_valid(c_ov),
    .out_last(c_ol), .out_ch(c_och), .out_ready(c_ordy));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    total++; if (a_ready !== 4'b0000 || b_ready !== 4'b0000 || c_ready !== 3'b000) begin
      bad++; $display("FAIL reset_ready got=%b/%b/%b exp=0", a_ready, b_ready, c_ready); end
    total++; if ({a_ov, a_ol, a_och, a_od} !== 14'd0) begin
      bad++; $display("FAIL reset_a got=%b,%b,%0d,%h exp=0", a_ov, a_ol, a_och, a_od); end
    total++; if ({b_ov, b_ol, b_och, b_od} !== 14'd0 || {c_ov, c_ol, c_och, c_od} !== 14'd0) begin
      bad++; $display("FAIL reset_bc got=%b%b%h/%b%b%h exp=0", b_ov, b_och, b_od, c_ov, c_och, c_od); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    a_sel = 2'd2; a_valid = 4'b0100; a_last = 4'b0100; a_data[20 +: 10] = 10'h155;
    #1;
    total++; if (a_ready !== 4'b0100) begin
      bad++; $display("FAIL single_ready got=%b exp=%b", a_ready, 4'b0100); end
    tick();
    a_valid = 4'b0000;
    total++; if ({a_ov, a_od, a_och, a_ol} !== {1'b1, 10'h155, 2'd2, 1'b1}) begin
      bad++; $display("FAIL single_out got=v%b d%h ch%0d l%b exp=v1 d155 ch2 l1", a_ov, a_od, a_och, a_ol); end
    tick();
  endtask

  task automatic test_lock();
    logic [9:0] exp_d [3];
    exp_d[0] = 10'h011; exp_d[1] = 10'h012; exp_d[2] = 10'h013;
    a_sel = 2'd1; a_valid = 4'b0010; a_last = 4'b0000;
    a_data[30 +: 10] = 10'h033;
    for (int b = 0; b < 3; b++) begin
      a_data[10 +: 10] = exp_d[b];
      a_last[1] = (b == 2);
      #1;
      total++; if (a_ready !== 4'b0010) begin
        bad++; $display("FAIL lock_ready%0d got=%b exp=0010", b, a_ready); end
      tick();
      if (b == 0) begin a_sel = 2'd3; a_valid = 4'b1010; a_last[3] = 1'b1; end
      total++; if ({a_ov, a_och, a_od, a_ol} !== {1'b1, 2'd1, exp_d[b], (b == 2)}) begin
        bad++; $display("FAIL lock_beat%0d got=v%b ch%0d d%h l%b exp ch1 d%h", b, a_ov, a_och, a_od, a_ol, exp_d[b]); end
    end
    a_valid = 4'b1000;
    #1;
    total++; if (a_ready !== 4'b1000) begin
      bad++; $display("FAIL lock_after_ready got=%b exp=1000", a_ready); end
    tick();
    a_valid = 4'b0000;
    total++; if ({a_ov, a_och, a_od} !== {1'b1, 2'd3, 10'h033}) begin
      bad++; $display("FAIL lock_after_out got=v%b ch%0d d%h exp=v1 ch3 d033", a_ov, a_och, a_od); end
    tick();
    total++; if (a_ov !== 1'b0) begin
      bad++; $display("FAIL lock_drain got=%b exp=0", a_ov); end
  endtask

  task automatic test_rr();
    b_valid = 4'b1111; b_last = 4'b1111; b_ordy = 1'b1;
    for (int i = 0; i < 4; i++) b_data[i*10 +: 10] = 10'(10'h100 + i);
    for (int k = 0; k < 6; k++) begin
      tick();
      total++; if ({b_ov, b_och, b_od} !== {1'b1, 2'(k % 4), 10'(10'h100 + (k % 4))}) begin
        bad++; $display("FAIL rr_%0d got=v%b ch%0d d%h exp=v1 ch%0d", k, b_ov, b_och, b_od, k % 4); end
    end
    b_valid = 4'b0000;
    tick();
  endtask

  task automatic test_stall();
    b_ordy = 1'b0; b_valid = 4'b0100; b_data[20 +: 10] = 10'h0AA;
    tick();
    b_valid = 4'b1000; b_data[30 +: 10] = 10'h0BB;
    for (int k = 0; k < 5; k++) begin
      total++; if (b_ready !== 4'b0000 || {b_ov, b_och, b_od} !== {1'b1, 2'd2, 10'h0AA}) begin
        bad++; $display("FAIL stall_%0d got=r%b v%b ch%0d d%h exp=r0000 v1 ch2 d0aa", k, b_ready, b_ov, b_och, b_od); end
      tick();
    end
    b_ordy = 1'b1;
    #1;
    total++; if (b_ready !== 4'b1000) begin
      bad++; $display("FAIL stall_release_ready got=%b exp=1000", b_ready); end
    tick();
    b_valid = 4'b0000;
    total++; if ({b_ov, b_och, b_od} !== {1'b1, 2'd3, 10'h0BB}) begin
      bad++; $display("FAIL stall_next got=v%b ch%0d d%h exp=v1 ch3 d0bb", b_ov, b_och, b_od); end
    tick();
  endtask

  task automatic test_oor();
    c_sel = 2'd3; c_valid = 3'b111; c_last = 3'b111; c_data = {10'h3C3, 10'h2C2, 10'h1C1};
    for (int k = 0; k < 2; k++) begin
      #1;
      total++; if (c_ready !== 3'b000) begin
        bad++; $display("FAIL oor_ready%0d got=%b exp=000", k, c_ready); end
      tick();
      total++; if (c_ov !== 1'b0) begin
        bad++; $display("FAIL oor_valid%0d got=%b exp=0", k, c_ov); end
    end
    c_valid = 3'b000;
  endtask

  task automatic test_reset_mid();
    a_sel = 2'd2; a_valid = 4'b0100; a_last = 4'b0000; a_data[20 +: 10] = 10'h0C1;
    b_valid = 4'b0100; b_last = 4'b0000; b_data[20 +: 10] = 10'h0C1;
    tick();
    total++; if ({a_ov, a_och, b_ov, b_och} !== {1'b1, 2'd2, 1'b1, 2'd2}) begin
      bad++; $display("FAIL rmid_pre got=a%b/%0d b%b/%0d exp=1/2", a_ov, a_och, b_ov, b_och); end
    rst = 1'b1;
    #1;
    total++; if (a_ready !== 4'b0000 || b_ready !== 4'b0000) begin
      bad++; $display("FAIL rmid_ready_in_rst got=%b/%b exp=0", a_ready, b_ready); end
    tick();
    total++; if ({a_ov, a_od, a_och, a_ol, b_ov, b_od, b_och, b_ol} !== 28'd0) begin
      bad++; $display("FAIL rmid_out got=a%b%h%0d b%b%h%0d exp=0", a_ov, a_od, a_och, b_ov, b_od, b_och); end
    rst = 1'b0;
    a_sel = 2'd0; a_valid = 4'b0101; a_last = 4'b0001; a_data[0 +: 10] = 10'h0D0;
    b_valid = 4'b1111; b_last = 4'b1111;
    for (int i = 0; i < 4; i++) b_data[i*10 +: 10] = 10'(10'h200 + i);
    #1;
    total++; if (a_ready !== 4'b0001 || b_ready !== 4'b0001) begin
      bad++; $display("FAIL rmid_unlock_ready got=%b/%b exp=0001", a_ready, b_ready); end
    tick();
    total++; if ({a_och, a_od, b_och, b_od} !== {2'd0, 10'h0D0, 2'd0, 10'h200}) begin
      bad++; $display("FAIL rmid_after got=a%0d/%h b%0d/%h exp=0/0d0 0/200", a_och, a_od, b_och, b_od); end
    a_valid = 4'b0000; b_valid = 4'b0000;
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_lock();
    test_rr();
    test_stall();
    test_oor();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
